rv32i_memarbiter: RTL and testbench

Single-port memory arbiter for the RV32I pipeline. Shares one synchronous, 1-cycle-read-latency RAM port between the instruction-fetch requester (ifTop) and the data requester (memTop), so the core can run against a single-port RAM. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. The block sits between the IF/MEM stages and the RAM, replacing their direct RAM connections.

---
 rtl/rv32i_memarbiter_pkg.sv | 14 +
 rtl/rv32i_memarbiter_starve_cnt.sv | 36 +++
 rtl/rv32i_memarbiter.sv | 83 ++++++++
 tb/tb_rv32i_memarbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_memarbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package rv32i_memarbiter_pkg;

  localparam int unsigned AddrWDefault = 30;
  localparam int unsigned DataWDefault = 32;

  // Which requester owns the read response arriving next cycle.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_t;

endpackage

// File: rtl/rv32i_memarbiter_starve_cnt.sv
// Saturating count of consecutive cycles a fetch request has been denied.
module rv32i_memarbiter_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == CntMax);

endmodule

// File: rtl/rv32i_memarbiter.sv
// Shares one 1-cycle-latency RAM port between fetch and data; data wins unless
// fetch has been starved for STARVE_MAX cycles.
module rv32i_memarbiter
  import rv32i_memarbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic        starved;
  owner_t      rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  rv32i_memarbiter_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (if_req && !if_gnt),
    .clr  (!if_req || if_gnt),
    .sat  (starved)
  );

  // Fetch wins when alone or when it has waited out the starvation limit.
  assign if_gnt = if_req && (!d_req || starved);
  assign d_gnt  = d_req && !if_gnt;

  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_we    = d_gnt && d_we;
  assign mem_be    = mem_we ? d_be : 4'b0000;
  assign mem_wdata = d_wdata;

  always_comb begin
    rd_owner_d = OwnNone;
    if (if_gnt) begin
      rd_owner_d = OwnIf;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OwnD;
    end
  end

  assign if_rvalid = (rd_owner_q == OwnIf);
  assign d_rvalid  = (rd_owner_q == OwnD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= OwnNone;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
    end
  end

  // Present the RAM word directly while valid, else the last delivered word.
  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_rv32i_memarbiter.sv
// Randomised and directed checks of rv32i_memarbiter against a cycle-level reference model.
module tb_rv32i_memarbiter;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  rv32i_memarbiter #(
    .ADDR_W(30), .DATA_W(32), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, 64 words, 1-cycle read latency.
  logic [31:0] ram [64];
  logic        ram_load = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [31:0] load_val = '0;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr[5:0]];
    if (ram_load) begin
      ram[load_idx] <= load_val;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] shadow [64];
  int          total = 0;
  int          bad = 0;
  int          waited = 0;
  logic        exp_if_v = 1'b0, exp_d_v = 1'b0;
  logic [31:0] exp_if_data = '0, exp_d_data = '0;
  logic [31:0] last_if = '0, last_d = '0;
  logic        g_if = 1'b0, g_d = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    ram_load = 1'b1;
    load_idx = 6'(idx);
    load_val = val;
    shadow[idx] = val;
    @(posedge clk);
    #1;
    ram_load = 1'b0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: check responses and grants mid-cycle, then advance the model.
  task automatic step();
    logic want_if, want_d;
    @(negedge clk);
    check("if_rvalid", 64'(if_rvalid), 64'(exp_if_v));
    check("if_rdata", 64'(if_rdata), 64'(exp_if_v ? exp_if_data : last_if));
    check("d_rvalid", 64'(d_rvalid), 64'(exp_d_v));
    check("d_rdata", 64'(d_rdata), 64'(exp_d_v ? exp_d_data : last_d));
    if (exp_if_v) last_if = exp_if_data;
    if (exp_d_v) last_d = exp_d_data;

    want_if = if_req && (!d_req || waited == SM);
    want_d  = d_req && !want_if;
    check("if_gnt", 64'(if_gnt), 64'(want_if));
    check("d_gnt", 64'(d_gnt), 64'(want_d));
    check("mem_we", 64'(mem_we), 64'(want_d && d_we));
    check("mem_be", 64'(mem_be), 64'((want_d && d_we) ? d_be : 4'b0000));
    check("mem_addr", 64'(mem_addr), 64'(want_d ? d_addr : if_addr));
    if (want_d && d_we) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));

    exp_if_v    = want_if;
    exp_if_data = shadow[if_addr[5:0]];
    exp_d_v     = want_d && !d_we;
    exp_d_data  = shadow[d_addr[5:0]];
    if (want_d && d_we) shadow[d_addr[5:0]] = merge(shadow[d_addr[5:0]], d_wdata, d_be);
    if (if_req && !want_if) waited = (waited < SM) ? waited + 1 : SM;
    else waited = 0;
    g_if = want_if;
    g_d  = want_d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_if_v = 1'b0;
    exp_d_v  = 1'b0;
    last_if  = '0;
    last_d   = '0;
    waited   = 0;
  endtask

  initial begin
    logic [5:0] k;
    // Zero the RAM while the DUT is in reset, then seed a few fetch words.
    for (int i = 0; i < 64; i++) preload(i, 32'h0);
    preload(0, 32'h1111_0000);
    preload(1, 32'h2222_0001);
    preload(2, 32'h3333_0002);
    preload(16, 32'hCAFE_F00D);

    // Test 1: reset state, then release with no requests.
    model_reset();
    check("rst_if_rvalid", 64'(if_rvalid), 64'h0);
    check("rst_d_rvalid", 64'(d_rvalid), 64'h0);
    check("rst_if_rdata", 64'(if_rdata), 64'h0);
    check("rst_d_rdata", 64'(d_rdata), 64'h0);
    reset = 1'b1;
    step();
    step();

    // Test 2: lone fetch of 0x10.
    if_req = 1'b1; if_addr = 30'h10;
    step();
    if_req = 1'b0;
    check("fetch_rvalid", 64'(if_rvalid), 64'h1);
    check("fetch_rdata", 64'(if_rdata), 64'hCAFE_F00D);
    step();
    step();
    check("fetch_hold", 64'(if_rdata), 64'hCAFE_F00D);

    // Test 3: partial write then read-back of 0x20.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    step();
    check("wr_no_rvalid", 64'(d_rvalid), 64'h0);
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    check("rd_rvalid", 64'(d_rvalid), 64'h1);
    check("rd_rdata", 64'(d_rdata), 64'h0000_BEEF);
    step();

    // Test 4: continuous contention; fetch must win on cycle STARVE_MAX+1 only.
    if_req = 1'b1; if_addr = 30'h1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20;
    for (int c = 1; c <= 6; c++) begin
      step();
      check("starve_if_gnt", 64'(g_if), 64'(c == SM + 1));
    end
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Test 5: back-to-back fetches of 0, 1, 2.
    if_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      if_addr = 30'(a);
      step();
    end
    if_req = 1'b0;
    step();
    check("b2b_last", 64'(if_rdata), 64'h3333_0002);
    step();

    // Test 6: reset right after a data-read grant drops the response.
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h20;
    step();
    d_req = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_drop_rvalid", 64'(d_rvalid), 64'h0);
    check("rst_drop_rdata", 64'(d_rdata), 64'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step();
    step();

    // Randomised traffic; requests are held until granted.
    for (int n = 0; n < 1500; n++) begin
      if (!if_req || g_if) begin
        if_req  = ($urandom % 4) != 0;
        if_addr = 30'($urandom % 64);
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom % 2) != 0;
        d_we    = ($urandom % 2) != 0;
        k       = 6'($urandom);
        d_addr  = 30'(k);
        d_be    = 4'($urandom);
        d_wdata = $urandom;
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
